// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter: sequential fetch addresses over a request/grant
// port, with stall, delayed-branch redirect, flush, and a sticky misalign fault.
module pc_fetch_ctrl #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int                 INST_LOG2    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              fetch_gnt_i,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              misalign_o
);

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] STEP       = {{(ADDR_W-1){1'b0}}, 1'b1} << INST_LOG2;
  // STEP-1 is zero when INST_LOG2 is 0, so the check collapses to constant 0.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = STEP - {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_target;
  logic              pending_valid;
  logic              misalign;
  logic              ce;
  logic              accept;
  logic [ADDR_W-1:0] next_pc;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  // Handshake: fetch_req_o is valid, fetch_gnt_i is ready; a fetch of
  // fetch_addr_o transfers only on an edge where both are high, and the
  // address stays stable while the request waits for a grant.
  always_comb begin
    fetch_req_o = (state == RUN) & ~stall_i & ~misalign & ~flush_i;
    accept      = fetch_req_o & fetch_gnt_i;
    if (pending_valid)      next_pc = pending_target;
    else if (branch_flag_i) next_pc = branch_target_i;
    else                    next_pc = pc + STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= OFF;
      ce             <= 1'b0;
      pc             <= RESET_VECTOR;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      misalign       <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          state <= RUN;
          ce    <= 1'b1;
        end
        RUN: begin
          if (flush_i) begin
            pc            <= new_pc_i;
            pending_valid <= 1'b0;
            misalign      <= is_misaligned(new_pc_i);
          end else if (accept) begin
            // The granted instruction is the delay slot; redirect applies after it.
            pc            <= next_pc;
            pending_valid <= 1'b0;
            misalign      <= is_misaligned(next_pc);
          end else if (branch_flag_i) begin
            pending_valid  <= 1'b1;
            pending_target <= branch_target_i;
          end
        end
        default: begin
          state <= OFF;
          ce    <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o         = pc;
  assign fetch_addr_o = pc;
  assign ce_o         = ce;
  assign misalign_o   = misalign;

endmodule
